serial_pattern_source: RTL and testbench

- Parallel-to-serial stimulus/stream source.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB first, one bit per clk, on dout.
- dout drives the serial din input of the downstream sequence-detector stages (Mealy/Moore).
- Replaces ad-hoc testbench shifting with a synthesizable, cycle-exact serializer.

---
 rtl/sps_defs.sv | 21 ++
 rtl/serial_pattern_source.sv | 183 ++++++++++++++++++
 tb/tb_serial_pattern_source.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sps_defs.sv
// Shared definitions for the serial pattern source: state encodings,
// the default word width and a counter-width helper.
package sps_defs;

  // FSM state encodings.
  typedef enum logic [1:0] {
    SPS_IDLE  = 2'd0,
    SPS_SHIFT = 2'd1,
    SPS_GAP   = 2'd2
  } sps_state_e;

  // Default number of bits per serialized word.
  localparam int SPS_WIDTH_DEF = 16;

  // Width of a counter that must hold values 0..n-1. Never returns less
  // than one bit, so degenerate parameter choices still yield legal vectors.
  function automatic int sps_cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_pattern_source.sv
// Parallel-to-serial stimulus source. Accepts a WIDTH-bit word over a
// valid/ready handshake and shifts it out MSB first, one bit per clock,
// on dout. An optional run of GAP idle cycles follows every word.
//
// Build option: define SPS_PREFETCH_EN to add a one-entry hold register so
// the next word can be accepted while the current one is shifting; with
// GAP=0 this yields a continuous, bubble-free bit stream.
module serial_pattern_source
  import sps_defs::*;
#(
  parameter int WIDTH = SPS_WIDTH_DEF,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int GAP_W = sps_cnt_width(GAP + 1);

  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] BIT_PRELST = CNT_W'(WIDTH - 2);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  sps_state_e       state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             dout_valid_q;
  logic             busy_q;
  logic             done_q;

  logic             load_fire;
  logic             last_bit;
  logic             gap_last;
  logic             word_end;
  logic             restart;
  logic [WIDTH-1:0] restart_word;

  // The bit on dout is always the MSB of the shift register; the register is
  // cleared whenever no word bit is being presented, so dout is 0 then.
  assign dout       = shift_q[WIDTH-1];
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

  assign load_fire = load_valid && load_ready;
  assign last_bit  = (bit_cnt_q == BIT_LAST);
  assign gap_last  = (gap_cnt_q == GAP_LAST);

  // A word "ends" at the edge where the stream could immediately restart:
  // after the LSB when there is no gap, or after the final gap cycle.
  assign word_end = ((state_q == SPS_SHIFT) && last_bit && (GAP == 0)) ||
                    ((state_q == SPS_GAP) && gap_last);

`ifdef SPS_PREFETCH_EN
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;
  logic             hold_fill;
  logic             hold_drain;

  assign load_ready = (state_q == SPS_IDLE) || !hold_full_q;

  // At a word end a buffered word takes precedence; if the buffer is empty a
  // word being accepted in that very cycle is forwarded straight into the
  // shift register instead of taking a detour through the hold register.
  assign restart      = word_end && (hold_full_q || load_fire);
  assign restart_word = hold_full_q ? hold_q : load_data;
  assign hold_drain   = word_end && hold_full_q;
  assign hold_fill    = load_fire && (state_q != SPS_IDLE) &&
                        !(word_end && !hold_full_q);

  // Hold register: filled by accepts outside IDLE, drained at a word end.
  // A drain and a fill on the same edge leave it full with the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      if (hold_fill) begin
        hold_q <= load_data;
      end
      hold_full_q <= hold_fill || (hold_full_q && !hold_drain);
    end
  end
`else
  // Without prefetch a word is only ever accepted from IDLE.
  assign load_ready   = (state_q == SPS_IDLE);
  assign restart      = 1'b0;
  assign restart_word = load_data;
`endif

  // Main FSM: sequences IDLE -> SHIFT -> (GAP) and drives all registered
  // outputs for the cycle that follows each edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below reads the value from before this edge.
    if (rst) begin
      state_q      <= SPS_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      unique case (state_q)
        SPS_IDLE: begin
          if (load_fire) begin
            state_q      <= SPS_SHIFT;
            shift_q      <= load_data;
            bit_cnt_q    <= '0;
            dout_valid_q <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
          end
        end

        SPS_SHIFT: begin
          if (!last_bit) begin
            // Present the next lower bit; flag done for the LSB cycle.
            shift_q   <= {shift_q[WIDTH-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            done_q    <= (bit_cnt_q == BIT_PRELST);
          end else if (GAP > 0) begin
            state_q      <= SPS_GAP;
            shift_q      <= '0;
            gap_cnt_q    <= '0;
            dout_valid_q <= 1'b0;
            done_q       <= 1'b0;
          end else if (restart) begin
            // Back-to-back word: its MSB follows the LSB with no bubble.
            shift_q   <= restart_word;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
          end else begin
            state_q      <= SPS_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
          end
        end

        SPS_GAP: begin
          if (!gap_last) begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end else if (restart) begin
            state_q      <= SPS_SHIFT;
            shift_q      <= restart_word;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            dout_valid_q <= 1'b1;
          end else begin
            state_q   <= SPS_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            busy_q    <= 1'b0;
          end
        end

        default: begin
          state_q      <= SPS_IDLE;
          shift_q      <= '0;
          bit_cnt_q    <= '0;
          gap_cnt_q    <= '0;
          dout_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_source.sv
// Directed testbench for serial_pattern_source. Two instances run side by
// side: one with GAP=0 and one with GAP=3. Tests specific to the prefetch
// build are compiled only when SPS_PREFETCH_EN is defined.
module tb_serial_pattern_source;

  localparam int W = 16;
`ifdef SPS_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] d0 = '0;
  logic [W-1:0] d3 = '0;
  logic         v0 = 1'b0;
  logic         v3 = 1'b0;

  logic r0, o0, ov0, b0, dn0;
  logic r3, o3, ov3, b3, dn3;

  // Packed status {dout, dout_valid, busy, done, load_ready}.
  logic [4:0] st0, st3;
  assign st0 = {o0, ov0, b0, dn0, r0};
  assign st3 = {o3, ov3, b3, dn3, r3};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_pattern_source #(.WIDTH(W), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .load_data(d0), .load_valid(v0),
    .load_ready(r0), .dout(o0), .dout_valid(ov0), .busy(b0), .done(dn0)
  );

  serial_pattern_source #(.WIDTH(W), .GAP(3)) dut3 (
    .clk(clk), .rst(rst), .load_data(d3), .load_valid(v3),
    .load_ready(r3), .dout(o3), .dout_valid(ov3), .busy(b3), .done(dn3)
  );

  // Two reset edges, inputs idle; returns at a falling edge with rst low.
  task automatic do_reset();
    @(negedge clk);
    v0 = 1'b0; v3 = 1'b0; rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reset values on both instances, then a few idle cycles.
  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      total++;
      if (st0 !== 5'b00001) begin
        bad++;
        $display("FAIL reset_g0 c=%0d got=%b exp=00001", c, st0);
      end
      total++;
      if (st3 !== 5'b00001) begin
        bad++;
        $display("FAIL reset_g3 c=%0d got=%b exp=00001", c, st3);
      end
      @(negedge clk);
    end
  endtask

  // One word, MSB first, done on the LSB cycle, idle afterwards.
  task automatic test_basic();
    logic [W-1:0] w;
    logic [4:0]   exp;
    w = 16'h4655;
    d0 = w; v0 = 1'b1;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      v0 = 1'b0;
      exp = {w[W-1-k], 1'b1, 1'b1, (k == W - 1), PF};
      total++;
      if (st0 !== exp) begin
        bad++;
        $display("FAIL basic bit=%0d got=%b exp=%b", k, st0, exp);
      end
    end
    @(negedge clk);
    total++;
    if (st0 !== 5'b00001) begin
      bad++;
      $display("FAIL basic_end got=%b exp=00001", st0);
    end
  endtask

  // Reset on the 5th bit aborts the word with no done pulse.
  task automatic test_rst_mid();
    logic [W-1:0] w;
    logic [4:0]   exp;
    w = 16'h4655;
    d0 = w; v0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      v0 = 1'b0;
      exp = {w[W-1-k], 1'b1, 1'b1, 1'b0, PF};
      total++;
      if (st0 !== exp) begin
        bad++;
        $display("FAIL rst_mid bit=%0d got=%b exp=%b", k, st0, exp);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (st0 !== 5'b00001) begin
      bad++;
      $display("FAIL rst_mid_after got=%b exp=00001", st0);
    end
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      total++;
      if (st0 !== 5'b00001) begin
        bad++;
        $display("FAIL rst_mid_idle c=%0d got=%b exp=00001", c, st0);
      end
    end
  endtask

`ifndef SPS_PREFETCH_EN
  // A word offered mid-shift is ignored; the running word is untouched.
  task automatic test_ignore();
    logic [W-1:0] w;
    logic [4:0]   exp;
    w = 16'h4655;
    d0 = w; v0 = 1'b1;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      exp = {w[W-1-k], 1'b1, 1'b1, (k == W - 1), 1'b0};
      total++;
      if (st0 !== exp) begin
        bad++;
        $display("FAIL ignore bit=%0d got=%b exp=%b", k, st0, exp);
      end
      v0 = (k == 3);
      d0 = (k == 3) ? 16'h0001 : w;
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (st0 !== 5'b00001) begin
        bad++;
        $display("FAIL ignore_end c=%0d got=%b exp=00001", c, st0);
      end
    end
  endtask
`endif

  // GAP=3 with load_valid held high: 16 ones, 3 gap cycles, then the next
  // word (via an IDLE accept, or straight from the hold register).
  task automatic test_gap();
    logic [4:0] exp;
    logic       ev;
    d3 = 16'hFFFF; v3 = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      ev  = (c <= 16) || (c == 21) || (PF && c == 20);
      exp = {ev, ev, (c != 20) || PF, (c == 16), (c == 20) || (PF && c == 1)};
      total++;
      if (st3 !== exp) begin
        bad++;
        $display("FAIL gap c=%0d got=%b exp=%b", c, st3, exp);
      end
    end
    v3 = 1'b0;
    do_reset();
  endtask

`ifdef SPS_PREFETCH_EN
  // Two words streamed with no bubble: 32 valid cycles, done at 16 and 32.
  task automatic test_stream();
    logic [2*W-1:0] w;
    logic [4:0]     exp;
    w = 32'hA5A5_5A5A;
    d0 = w[2*W-1:W]; v0 = 1'b1;
    for (int c = 1; c <= 2 * W; c++) begin
      @(negedge clk);
      exp = {w[2*W-c], 1'b1, 1'b1, (c == 16) || (c == 32), (c == 1) || (c >= 17)};
      total++;
      if (st0 !== exp) begin
        bad++;
        $display("FAIL stream c=%0d got=%b exp=%b", c, st0, exp);
      end
      if (c == 1) d0 = w[W-1:0];
      if (c == 2) v0 = 1'b0;
    end
    @(negedge clk);
    total++;
    if (st0 !== 5'b00001) begin
      bad++;
      $display("FAIL stream_end got=%b exp=00001", st0);
    end
  endtask

  // Third word offered while the hold register is full waits for the drain
  // and is then accepted; all three words arrive back to back.
  task automatic test_back_to_back();
    logic [3*W-1:0] w;
    logic [4:0]     exp;
    logic           er;
    w = 48'hF00F_0FF0_C3C3;
    d0 = w[3*W-1:2*W]; v0 = 1'b1;
    for (int c = 1; c <= 3 * W; c++) begin
      @(negedge clk);
      er  = (c == 1) || (c == 17) || (c >= 33);
      exp = {w[3*W-c], 1'b1, 1'b1, (c % 16 == 0), er};
      total++;
      if (st0 !== exp) begin
        bad++;
        $display("FAIL b2b c=%0d got=%b exp=%b", c, st0, exp);
      end
      if (c == 1) d0 = w[2*W-1:W];
      if (c == 2) d0 = w[W-1:0];
      if (c == 18) v0 = 1'b0;
    end
    @(negedge clk);
    total++;
    if (st0 !== 5'b00001) begin
      bad++;
      $display("FAIL b2b_end got=%b exp=00001", st0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_rst_mid();
`ifndef SPS_PREFETCH_EN
    test_ignore();
`endif
    test_gap();
`ifdef SPS_PREFETCH_EN
    test_stream();
    test_back_to_back();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
